vram_arbiter: RTL

- Shares the single-port video memory between two requesters.
- The display fetch path reads pixels to feed the vga_timing-driven output. The draw engine issues read/write accesses.
- Display has priority. A bounded-starvation guard gives the draw engine a slot unless the display fetcher flags urgency.
- One memory access per clock. Commands are registered, and read data is routed back to its owner through a tag pipeline.

---
 rtl/vram_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Two-requester arbiter for the single-port VRAM (display / draw)
//            with registered commands and a tagged read-return pipeline.
// Revision : 1.0
// ============================================================================
module vram_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              disp_req_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    input  logic              disp_urgent_i,
    output logic              disp_ack_o,
    output logic              disp_rvalid_o,
    output logic [DATA_W-1:0] disp_rdata_o,
    input  logic              draw_req_i,
    input  logic              draw_we_i,
    input  logic [ADDR_W-1:0] draw_addr_i,
    input  logic [DATA_W-1:0] draw_wdata_i,
    output logic              draw_ready_o,
    output logic              draw_rvalid_o,
    output logic [DATA_W-1:0] draw_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [MEM_LAT:0]  tag_vld_q;
    logic [MEM_LAT:0]  tag_own_q;   // 1 = draw engine owns the read
    logic              disp_rvalid_q, draw_rvalid_q;
    logic [DATA_W-1:0] disp_rdata_q, draw_rdata_q;

    logic w_disp_acc, w_draw_acc, w_rd_issue, w_ret_vld, w_ret_own;

    always_comb begin
        w_disp_acc = !reset_i && disp_req_i &&
                     (disp_urgent_i || !draw_req_i || (starve_cnt_q < c_starve_max));
        w_draw_acc = !reset_i && draw_req_i && !w_disp_acc;
        w_rd_issue = w_disp_acc || (w_draw_acc && !draw_we_i);
        w_ret_vld  = tag_vld_q[MEM_LAT];
        w_ret_own  = tag_own_q[MEM_LAT];

        starve_cnt_d = 4'd0;
        if (draw_req_i && !w_draw_acc) begin
            starve_cnt_d = (starve_cnt_q >= c_starve_max) ? c_starve_max
                                                          : starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt_q  <= 4'd0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            tag_vld_q     <= '0;
            tag_own_q     <= '0;
            disp_rvalid_q <= 1'b0;
            draw_rvalid_q <= 1'b0;
            disp_rdata_q  <= '0;
            draw_rdata_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            mem_en_q     <= w_disp_acc || w_draw_acc;
            mem_we_q     <= w_draw_acc && draw_we_i;
            if (w_disp_acc) begin
                mem_addr_q <= disp_addr_i;
            end else if (w_draw_acc) begin
                mem_addr_q  <= draw_addr_i;
                mem_wdata_q <= draw_wdata_i;
            end

            // Tag stage k lines up with the memory cycle issue+k.
            tag_vld_q <= {tag_vld_q[MEM_LAT-1:0], w_rd_issue};
            tag_own_q <= {tag_own_q[MEM_LAT-1:0], w_draw_acc};

            disp_rvalid_q <= w_ret_vld && !w_ret_own;
            draw_rvalid_q <= w_ret_vld &&  w_ret_own;
            if (w_ret_vld && !w_ret_own) disp_rdata_q <= mem_rdata_i;
            if (w_ret_vld &&  w_ret_own) draw_rdata_q <= mem_rdata_i;
        end
    end

    assign disp_ack_o    = w_disp_acc;
    assign draw_ready_o  = w_draw_acc;
    assign mem_en_o      = mem_en_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign disp_rvalid_o = disp_rvalid_q;
    assign disp_rdata_o  = disp_rdata_q;
    assign draw_rvalid_o = draw_rvalid_q;
    assign draw_rdata_o  = draw_rdata_q;

endmodule
`default_nettype wire
